// File: rtl/shim_pkg.sv
// Shared definitions for the shim release controller: sync header codes,
// terminate block types, FSM state encoding and the terminate classifier.
package shim_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  // Control block types that close a packet.
  localparam logic [7:0] BT_TERM0 = 8'h87;
  localparam logic [7:0] BT_TERM1 = 8'h99;
  localparam logic [7:0] BT_TERM2 = 8'hAA;
  localparam logic [7:0] BT_TERM3 = 8'hB4;
  localparam logic [7:0] BT_TERM4 = 8'hCC;
  localparam logic [7:0] BT_TERM5 = 8'hD2;
  localparam logic [7:0] BT_TERM6 = 8'hE1;
  localparam logic [7:0] BT_TERM7 = 8'hFF;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RELEASE = 1'b1
  } rel_state_e;

  // A word terminates a packet only if it is a control word whose block
  // type is one of the eight terminate codes.
  function automatic logic is_term(input logic [1:0] hdr, input logic [7:0] bt);
    logic bt_hit;
    bt_hit = (bt == BT_TERM0) || (bt == BT_TERM1) || (bt == BT_TERM2) ||
             (bt == BT_TERM3) || (bt == BT_TERM4) || (bt == BT_TERM5) ||
             (bt == BT_TERM6) || (bt == BT_TERM7);
    return (hdr == SYNC_CTRL) && bt_hit;
  endfunction

endpackage

// File: rtl/shim_term_det.sv
// Combinational terminate detector: flags a qualified word (vld high) that
// carries a terminate control block.
module shim_term_det
  import shim_pkg::*;
#(
  parameter int HDR_W = 2
) (
  input  logic             vld,
  input  logic [HDR_W-1:0] hdr,
  input  logic [7:0]       blk_type,
  output logic             term
);

  logic [1:0] hdr2;

  // Map the header onto the 2-bit sync code space the classifier expects.
  generate
    if (HDR_W == 2) begin : g_h2
      assign hdr2 = hdr;
    end else begin : g_hx
      assign hdr2 = (hdr == HDR_W'(SYNC_CTRL)) ? SYNC_CTRL : SYNC_DATA;
    end
  endgenerate

  assign term = vld & is_term(hdr2, blk_type);

endmodule

// File: rtl/shim_release_ctrl.sv
// Shim release controller: counts complete packets sitting in the shim queue
// and pops the queue only while at least one full packet is pending
// (store-and-forward). Back-to-back packets drain without a gap cycle.
// Optional build macro SHIM_WATERMARK_EN adds cut-through: release also starts
// once the queue fill level reaches WMARK, and is not dropped while the level
// remains at or above WMARK.
module shim_release_ctrl
  import shim_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int HDR_W  = 2,
  parameter int CNT_W  = 4,
  parameter int LVL_W  = 6,
  parameter int WMARK  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shim_wr,
  input  logic [HDR_W-1:0]  shim_inc,
  input  logic [DATA_W-1:0] shim_ind,
  input  logic              shim_empty,
  input  logic [HDR_W-1:0]  shim_outc,
  input  logic [DATA_W-1:0] shim_outd,
  input  logic [LVL_W-1:0]  shim_level,
  output logic              shimq_read,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic              rel_active,
  output logic              err_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rel_state_e       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             ovf_q, ovf_set;
  logic             in_term, out_term;
  logic             lvl_hi;
  logic             unused_bits;

  // Only the block-type byte matters for classification; the rest of each
  // data word passes through the queue untouched.
  assign unused_bits = ^{shim_ind, shim_outd, shim_level};

  assign rel_active = (state_q == ST_RELEASE);
  assign shimq_read = rel_active & ~shim_empty;
  assign pkt_cnt    = cnt_q;
  assign err_ovf    = ovf_q;

  shim_term_det #(.HDR_W(HDR_W)) u_wr_det (
    .vld      (shim_wr),
    .hdr      (shim_inc),
    .blk_type (shim_ind[7:0]),
    .term     (in_term)
  );

  shim_term_det #(.HDR_W(HDR_W)) u_hd_det (
    .vld      (shimq_read),
    .hdr      (shim_outc),
    .blk_type (shim_outd[7:0]),
    .term     (out_term)
  );

`ifdef SHIM_WATERMARK_EN
  assign lvl_hi = (32'(shim_level) >= 32'(WMARK));
`else
  assign lvl_hi = 1'b0;
`endif

  // Pending-packet counter: saturates on overflow, never wraps below zero.
  always_comb begin
    cnt_nxt = cnt_q;
    ovf_set = 1'b0;
    case ({in_term, out_term})
      2'b10: begin
        if (cnt_q == CNT_MAX) ovf_set = 1'b1;
        else                  cnt_nxt = cnt_q + CNT_W'(1);
      end
      2'b01: begin
        if (cnt_q != '0) cnt_nxt = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Release decision looks at the count after this cycle's update so a
  // terminate write releases on the very next cycle and the last terminate
  // pop closes the window immediately.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:    if ((cnt_nxt != '0) || lvl_hi) state_nxt = ST_RELEASE;
      ST_RELEASE: if (out_term && (cnt_nxt == '0) && !lvl_hi) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State, count and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      ovf_q   <= ovf_q | ovf_set;
    end
  end

endmodule
